// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment driver with per-slot blanking, blink and
// frame-coherent snapshot of the displayed data.
module seg_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_s1,
   input  logic [6:0] seg_s10,
   input  logic [6:0] seg_m1,
   input  logic [6:0] seg_m10,
   input  logic [6:0] seg_h1,
   input  logic [6:0] seg_h10,
   input  logic [5:0] dp_mask,
   input  logic [5:0] blink_mask,
   output logic [6:0] seg_out,
   output logic       dp_out,
   output logic [5:0] digit_en,
   output logic       frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t          st_q, st_d;
   logic [CW-1:0]   c_q, c_d;
   logic [2:0]      idx_q, idx_d;
   logic [BW-1:0]   bc_q, bc_d;
   logic            ph_q, ph_d;
   logic [5:0][6:0] seg_in, snap_seg_q;
   logic [5:0]      snap_dp_q, snap_bl_q;
   logic            snap_ph_q;
   logic            slot_wrap, frame_wrap, mute;

   assign seg_in     = {seg_h10, seg_h1, seg_m10, seg_m1, seg_s10, seg_s1};
   assign slot_wrap  = (c_q == C_LAST);
   assign frame_wrap = slot_wrap && (idx_q == 3'd5);

   always_comb begin
      c_d   = slot_wrap ? '0 : c_q + 1'b1;
      idx_d = frame_wrap ? 3'd0 : (slot_wrap ? idx_q + 3'd1 : idx_q);
      bc_d  = (bc_q == B_LAST) ? '0 : bc_q + 1'b1;
      ph_d  = (bc_q == B_LAST) ? ~ph_q : ph_q;
   end

   // Decide state from the counter value being loaded so SHOW lines up with c.
   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_BLANK: if (int'(c_d) >= BLANK_CYC) st_d = ST_SHOW;
         ST_SHOW:  if (slot_wrap && (BLANK_CYC > 0)) st_d = ST_BLANK;
         default:  st_d = ST_BLANK;
      endcase
   end

   always_comb begin
      digit_en   = '0;
      seg_out    = '0;
      dp_out     = 1'b0;
      frame_tick = frame_wrap;
      mute       = snap_bl_q[idx_q] & snap_ph_q;
      if (st_q == ST_SHOW) begin
         digit_en = 6'd1 << idx_q;
         if (!mute) begin
            seg_out = snap_seg_q[idx_q];
            dp_out  = snap_dp_q[idx_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q       <= ST_BLANK;
         c_q        <= '0;
         idx_q      <= 3'd0;
         bc_q       <= '0;
         ph_q       <= 1'b0;
         snap_seg_q <= seg_in;
         snap_dp_q  <= dp_mask;
         snap_bl_q  <= blink_mask;
         snap_ph_q  <= 1'b0;
      end else begin
         st_q  <= st_d;
         c_q   <= c_d;
         idx_q <= idx_d;
         bc_q  <= bc_d;
         ph_q  <= ph_d;
         // New frame data is captured on the same edge that returns to digit 0.
         if (frame_wrap) begin
            snap_seg_q <= seg_in;
            snap_dp_q  <= dp_mask;
            snap_bl_q  <= blink_mask;
            snap_ph_q  <= ph_q;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: vector table for scan/blink plus sequences for
// reset, snapshot coherence, mid-scan reset and a no-blank build.
module tb_seg_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] seg_s1, seg_s10, seg_m1, seg_m10, seg_h1, seg_h10;
   logic [5:0] dp_mask, blink_mask;
   logic [6:0] seg_out, seg_out_nb;
   logic       dp_out, dp_out_nb;
   logic [5:0] digit_en, digit_en_nb;
   logic       frame_tick, frame_tick_nb;

   int checks = 0;
   int errors = 0;
   int k = 0;

   always #5 clk = ~clk;

   seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(40)) dut (
      .clk(clk), .rst(rst),
      .seg_s1(seg_s1), .seg_s10(seg_s10), .seg_m1(seg_m1),
      .seg_m10(seg_m10), .seg_h1(seg_h1), .seg_h10(seg_h10),
      .dp_mask(dp_mask), .blink_mask(blink_mask),
      .seg_out(seg_out), .dp_out(dp_out), .digit_en(digit_en),
      .frame_tick(frame_tick)
   );

   seg_scan #(.SCAN_DIV(8), .BLANK_CYC(0), .BLINK_DIV(40)) dut_nb (
      .clk(clk), .rst(rst),
      .seg_s1(seg_s1), .seg_s10(seg_s10), .seg_m1(seg_m1),
      .seg_m10(seg_m10), .seg_h1(seg_h1), .seg_h10(seg_h10),
      .dp_mask(dp_mask), .blink_mask(blink_mask),
      .seg_out(seg_out_nb), .dp_out(dp_out_nb), .digit_en(digit_en_nb),
      .frame_tick(frame_tick_nb)
   );

   typedef struct {
      int         k;
      logic [5:0] en;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
   } vec_t;

   vec_t vt[17];

   function automatic vec_t mk(int kk, logic [5:0] en, logic [6:0] seg, logic dp, logic ft);
      vec_t v;
      v.k = kk; v.en = en; v.seg = seg; v.dp = dp; v.ft = ft;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int t);
      while (k < t) step();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("reset_outs_c%0d", i), {17'd0, digit_en, seg_out, dp_out, frame_tick}, 32'd0);
         check($sformatf("reset_outs_nb_c%0d", i),
               {17'd0, digit_en_nb, seg_out_nb, dp_out_nb, frame_tick_nb}, 32'd0);
      end
      rst = 1'b1;
      k = 0;
   endtask

   initial begin
      int ft_cnt, ft_bad;
      seg_s1 = 7'h01; seg_s10 = 7'h02; seg_m1 = 7'h03;
      seg_m10 = 7'h04; seg_h1 = 7'h05; seg_h10 = 7'h06;
      dp_mask = 6'b000001; blink_mask = 6'b000011;

      // k = edges since release; frame 0 snapshot phase 0, frame 1 phase 1, frame 2 phase 0
      vt[0]  = mk(1,  6'b000000, 7'h00, 1'b0, 1'b0);
      vt[1]  = mk(2,  6'b000001, 7'h01, 1'b1, 1'b0);
      vt[2]  = mk(7,  6'b000001, 7'h01, 1'b1, 1'b0);
      vt[3]  = mk(8,  6'b000000, 7'h00, 1'b0, 1'b0);
      vt[4]  = mk(9,  6'b000000, 7'h00, 1'b0, 1'b0);
      vt[5]  = mk(10, 6'b000010, 7'h02, 1'b0, 1'b0);
      vt[6]  = mk(18, 6'b000100, 7'h03, 1'b0, 1'b0);
      vt[7]  = mk(26, 6'b001000, 7'h04, 1'b0, 1'b0);
      vt[8]  = mk(34, 6'b010000, 7'h05, 1'b0, 1'b0);
      vt[9]  = mk(42, 6'b100000, 7'h06, 1'b0, 1'b0);
      vt[10] = mk(47, 6'b100000, 7'h06, 1'b0, 1'b1);
      vt[11] = mk(48, 6'b000000, 7'h00, 1'b0, 1'b0);
      vt[12] = mk(50, 6'b000001, 7'h00, 1'b0, 1'b0);
      vt[13] = mk(58, 6'b000010, 7'h00, 1'b0, 1'b0);
      vt[14] = mk(66, 6'b000100, 7'h03, 1'b0, 1'b0);
      vt[15] = mk(95, 6'b100000, 7'h06, 1'b0, 1'b1);
      vt[16] = mk(98, 6'b000001, 7'h01, 1'b1, 1'b0);

      do_reset(5);
      for (int i = 0; i < 17; i++) begin
         run_to(vt[i].k);
         check($sformatf("scan_k%0d", vt[i].k),
               {17'd0, digit_en, seg_out, dp_out, frame_tick},
               {17'd0, vt[i].en, vt[i].seg, vt[i].dp, vt[i].ft});
      end

      // No-blank build: always one digit on, 8 cycles each; frame_tick every 48
      do_reset(2);
      ft_cnt = 0; ft_bad = 0;
      for (int i = 1; i <= 144; i++) begin
         logic [5:0] exp_en;
         step();
         exp_en = 6'd1 << ((k / 8) % 6);
         check($sformatf("noblank_en_k%0d", k), {26'd0, digit_en_nb}, {26'd0, exp_en});
         if (frame_tick === 1'b1) begin
            ft_cnt++;
            if ((k % 48) != 47) ft_bad++;
         end
      end
      check("frame_tick_count", ft_cnt, 3);
      check("frame_tick_phase", ft_bad, 0);

      // Snapshot coherence
      blink_mask = 6'b000000;
      seg_s1 = 7'h3F;
      do_reset(3);
      run_to(2);
      check("snap_d0_old", {19'd0, digit_en, seg_out}, {19'd0, 6'b000001, 7'h3F});
      run_to(20);
      seg_s1 = 7'h06; seg_h10 = 7'h7F;
      run_to(42);
      check("snap_d5_same_frame", {19'd0, digit_en, seg_out}, {19'd0, 6'b100000, 7'h06});
      run_to(50);
      check("snap_d0_next_frame", {19'd0, digit_en, seg_out}, {19'd0, 6'b000001, 7'h06});
      run_to(90);
      check("snap_d5_next_frame", {19'd0, digit_en, seg_out}, {19'd0, 6'b100000, 7'h7F});

      // Mid-scan reset during SHOW of digit 3
      run_to(122);
      check("pre_reset_d3", {19'd0, digit_en, seg_out}, {19'd0, 6'b001000, 7'h04});
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_outs", {17'd0, digit_en, seg_out, dp_out, frame_tick}, 32'd0);
      seg_s1 = 7'h49;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      k = 0;
      run_to(1);
      check("after_reset_blank", {26'd0, digit_en}, 32'd0);
      run_to(2);
      check("after_reset_d0", {19'd0, digit_en, seg_out}, {19'd0, 6'b000001, 7'h49});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
